// File: rtl/jpc_regfile_sched.sv
// jpc_regfile_sched: arbitrates writeback and operand-fetch traffic onto one regfile port
module jpc_regfile_sched #(
  parameter int DATA_W = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_req_valid_I,
  output logic              op_req_ready_O,
  input  logic [4:0]        op_rs1_I,
  input  logic              op_rs1_en_I,
  input  logic [4:0]        op_rs2_I,
  input  logic              op_rs2_en_I,
  output logic              op_rsp_valid_O,
  input  logic              op_rsp_ready_I,
  output logic [DATA_W-1:0] op_rs1_data_O,
  output logic [DATA_W-1:0] op_rs2_data_O,
  output logic              op_rsp_err_O,
  input  logic              wb_valid_I,
  output logic              wb_ready_O,
  input  logic [4:0]        wb_rd_I,
  input  logic [DATA_W-1:0] wb_data_I,
  output logic              rf_idx_op_O,
  output logic [4:0]        rf_idx_O,
  output logic              rf_idx_valid_O,
  input  logic              rf_idx_ready_I,
  output logic              rf_rdata_ready_O,
  input  logic [DATA_W-1:0] rf_rdata_I,
  input  logic              rf_rdata_valid_I,
  input  logic              rf_wdata_ready_I,
  output logic [DATA_W-1:0] rf_wdata_O,
  output logic              rf_wdata_valid_O,
  output logic              busy_O
);
  typedef enum logic [3:0] {
    IDLE, WB_ISSUE, GAP_IDLE, RS1_ISSUE, RS1_WAIT, GAP_RS2, RS2_ISSUE, RS2_WAIT, RESP
  } state_t;
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
  state_t state, state_nx;
  logic wb_pend, op_pend, rs1_en, rs2_en;
  logic [4:0] wb_rd, rs1, rs2;
  logic [DATA_W-1:0] wb_data;
  logic [7:0] cnt;
  logic op_acc, wb_acc, skip1, skip2, tmo, wb_done;
  assign op_req_ready_O = (state == IDLE) && !op_pend;
  assign wb_ready_O = !wb_pend;
  assign op_acc = op_req_valid_I && op_req_ready_O;
  assign wb_acc = wb_valid_I && wb_ready_O && (wb_rd_I != 5'd0);
  assign skip1 = !rs1_en || (rs1 == 5'd0);
  assign skip2 = !rs2_en || (rs2 == 5'd0);
  assign tmo = cnt == TMO_LAST;
  assign wb_done = rf_idx_ready_I && rf_wdata_ready_I;
  assign rf_idx_valid_O = (state == WB_ISSUE) || (state == RS1_ISSUE && !skip1) || (state == RS2_ISSUE && !skip2);
  assign rf_idx_op_O = state == WB_ISSUE;
  assign rf_idx_O = !rf_idx_valid_O ? 5'd0 : (state == WB_ISSUE) ? wb_rd : (state == RS1_ISSUE) ? rs1 : rs2;
  assign rf_wdata_valid_O = state == WB_ISSUE;
  assign rf_wdata_O = (state == WB_ISSUE) ? wb_data : '0;
  assign rf_rdata_ready_O = (state == RS1_ISSUE && !skip1) || (state == RS2_ISSUE && !skip2) ||
                            (state == RS1_WAIT) || (state == RS2_WAIT);
  assign op_rsp_valid_O = state == RESP;
  assign busy_O = state != IDLE;
  // next state: a freshly accepted request may leave IDLE in the same cycle, writeback first
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = (wb_pend || wb_acc) ? WB_ISSUE : (op_pend || op_acc) ? RS1_ISSUE : IDLE;
      WB_ISSUE:  state_nx = wb_done ? GAP_IDLE : WB_ISSUE;
      GAP_IDLE:  state_nx = IDLE;
      RS1_ISSUE: state_nx = skip1 ? RS2_ISSUE : rf_idx_ready_I ? RS1_WAIT : RS1_ISSUE;
      RS1_WAIT:  state_nx = (rf_rdata_valid_I || tmo) ? GAP_RS2 : RS1_WAIT;
      GAP_RS2:   state_nx = RS2_ISSUE;
      RS2_ISSUE: state_nx = skip2 ? RESP : rf_idx_ready_I ? RS2_WAIT : RS2_ISSUE;
      RS2_WAIT:  state_nx = (rf_rdata_valid_I || tmo) ? RESP : RS2_WAIT;
      RESP:      state_nx = op_rsp_ready_I ? IDLE : RESP;
      default:   state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // holding registers, operand capture and read timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_pend <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      op_pend <= 1'b0;
      rs1 <= '0;
      rs2 <= '0;
      rs1_en <= 1'b0;
      rs2_en <= 1'b0;
      op_rs1_data_O <= '0;
      op_rs2_data_O <= '0;
      op_rsp_err_O <= 1'b0;
      cnt <= '0;
    end else begin
      if (wb_acc) begin
        wb_pend <= 1'b1;
        wb_rd <= wb_rd_I;
        wb_data <= wb_data_I;
      end else if (state == WB_ISSUE && wb_done) begin
        wb_pend <= 1'b0;
      end
      if (op_acc) begin
        op_pend <= 1'b1;
        rs1 <= op_rs1_I;
        rs2 <= op_rs2_I;
        rs1_en <= op_rs1_en_I;
        rs2_en <= op_rs2_en_I;
        op_rs1_data_O <= '0;
        op_rs2_data_O <= '0;
        op_rsp_err_O <= 1'b0;
      end else if (state == RESP && op_rsp_ready_I) begin
        op_pend <= 1'b0;
      end
      case (state)
        RS1_ISSUE: if (skip1) op_rs1_data_O <= '0; else if (rf_idx_ready_I) cnt <= '0;
        RS2_ISSUE: if (skip2) op_rs2_data_O <= '0; else if (rf_idx_ready_I) cnt <= '0;
        RS1_WAIT:
          if (rf_rdata_valid_I) op_rs1_data_O <= rf_rdata_I;
          else if (tmo) begin
            op_rs1_data_O <= '0;
            op_rsp_err_O <= 1'b1;
          end else cnt <= cnt + 8'd1;
        RS2_WAIT:
          if (rf_rdata_valid_I) op_rs2_data_O <= rf_rdata_I;
          else if (tmo) begin
            op_rs2_data_O <= '0;
            op_rsp_err_O <= 1'b1;
          end else cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jpc_regfile_sched.sv
// tb_jpc_regfile_sched: directed bench with a zero-wait regfile model behind the scheduler
module tb_jpc_regfile_sched;
  logic clk = 0, rst = 1;
  logic op_req_valid = 0, op_req_ready, op_rs1_en = 0, op_rs2_en = 0;
  logic [4:0] op_rs1 = 0, op_rs2 = 0, wb_rd = 0, rf_idx;
  logic op_rsp_valid, op_rsp_ready = 0, op_rsp_err;
  logic [31:0] op_rs1_data, op_rs2_data, wb_data = 0, rf_rdata = 0, rf_wdata;
  logic wb_valid = 0, wb_ready, rf_idx_op, rf_idx_valid, rf_rdata_ready, rf_rdata_valid = 0;
  logic rf_wdata_valid, busy;
  logic rf_idx_ready = 1, rf_wdata_ready = 1;
  logic [31:0] mem [32];
  logic [5:0] xlog [$];
  int rd_n = 0, wr_n = 0, gap_viol = 0, hang_idx = -1;
  logic prev_xfer = 0;
  int vec = 0, bad = 0;

  jpc_regfile_sched #(.DATA_W(32), .TMO_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .op_req_valid_I(op_req_valid), .op_req_ready_O(op_req_ready),
    .op_rs1_I(op_rs1), .op_rs1_en_I(op_rs1_en), .op_rs2_I(op_rs2), .op_rs2_en_I(op_rs2_en),
    .op_rsp_valid_O(op_rsp_valid), .op_rsp_ready_I(op_rsp_ready),
    .op_rs1_data_O(op_rs1_data), .op_rs2_data_O(op_rs2_data), .op_rsp_err_O(op_rsp_err),
    .wb_valid_I(wb_valid), .wb_ready_O(wb_ready), .wb_rd_I(wb_rd), .wb_data_I(wb_data),
    .rf_idx_op_O(rf_idx_op), .rf_idx_O(rf_idx), .rf_idx_valid_O(rf_idx_valid),
    .rf_idx_ready_I(rf_idx_ready), .rf_rdata_ready_O(rf_rdata_ready), .rf_rdata_I(rf_rdata),
    .rf_rdata_valid_I(rf_rdata_valid), .rf_wdata_ready_I(rf_wdata_ready),
    .rf_wdata_O(rf_wdata), .rf_wdata_valid_O(rf_wdata_valid), .busy_O(busy)
  );

  always #5 clk = ~clk;

  // regfile model: read data one cycle after index accept; hang_idx never answers
  always @(posedge clk) begin
    rf_rdata_valid <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[3] <= 32'h33;
      mem[5] <= 32'h11;
      mem[6] <= 32'h22;
      mem[7] <= 32'h77;
    end else if (rf_idx_valid && rf_idx_ready) begin
      xlog.push_back({rf_idx_op, rf_idx});
      if (rf_idx_op) begin
        wr_n <= wr_n + 1;
        if (rf_wdata_valid && rf_wdata_ready) mem[rf_idx] <= rf_wdata;
      end else begin
        rd_n <= rd_n + 1;
        if (int'(rf_idx) != hang_idx) begin
          rf_rdata_valid <= 1'b1;
          rf_rdata <= mem[rf_idx];
        end
      end
    end
    if (!rst && prev_xfer && rf_idx_valid) gap_viol <= gap_viol + 1;
    prev_xfer <= !rst && rf_idx_valid && rf_idx_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [4:0] a, input logic ae, input logic [4:0] b, input logic be);
    op_rs1 = a; op_rs1_en = ae; op_rs2 = b; op_rs2_en = be; op_req_valid = 1;
    tick();
    op_req_valid = 0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!op_rsp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic finish_rsp();
    op_rsp_ready = 1;
    tick();
    op_rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    vec++; if (op_req_ready !== 1'b1) begin bad++; $display("FAIL reset op_req_ready got %b want 1", op_req_ready); end
    vec++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL reset wb_ready got %b want 1", wb_ready); end
    vec++; if ({rf_idx_valid, rf_wdata_valid, rf_rdata_ready, op_rsp_valid, op_rsp_err, busy} !== 6'b0)
      begin bad++; $display("FAIL reset flags got %b want 000000",
        {rf_idx_valid, rf_wdata_valid, rf_rdata_ready, op_rsp_valid, op_rsp_err, busy}); end
    vec++; if ({rf_idx, rf_idx_op, rf_wdata, op_rs1_data, op_rs2_data} !== '0)
      begin bad++; $display("FAIL reset data idx=%h wd=%h rs1=%h rs2=%h want 0", rf_idx, rf_wdata, op_rs1_data, op_rs2_data); end
    rst = 0;
    tick();
  endtask

  task automatic test_fetch();
    int cyc, r0 = rd_n;
    send_op(5, 1, 6, 1);
    wait_rsp(cyc);
    vec++; if (cyc !== 6) begin bad++; $display("FAIL fetch latency got %0d want 6", cyc); end
    vec++; if (op_rs1_data !== 32'h11) begin bad++; $display("FAIL fetch rs1 got %h want 11", op_rs1_data); end
    vec++; if (op_rs2_data !== 32'h22) begin bad++; $display("FAIL fetch rs2 got %h want 22", op_rs2_data); end
    vec++; if (op_rsp_err !== 1'b0) begin bad++; $display("FAIL fetch err got %b want 0", op_rsp_err); end
    vec++; if (rd_n - r0 !== 2) begin bad++; $display("FAIL fetch read xfers got %0d want 2", rd_n - r0); end
    vec++; if (gap_viol !== 0) begin bad++; $display("FAIL fetch gap violations got %0d want 0", gap_viol); end
    finish_rsp();
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL fetch idle after rsp busy got %b want 0", busy); end
  endtask

  task automatic test_wb_priority();
    int cyc, n0 = xlog.size();
    wb_rd = 5; wb_data = 32'hAB; wb_valid = 1;
    send_op(5, 1, 0, 0);
    wb_valid = 0;
    wait_rsp(cyc);
    vec++; if (op_rsp_valid !== 1'b1) begin bad++; $display("FAIL prio response got %b want 1", op_rsp_valid); end
    vec++; if (xlog.size() < n0 + 2 || xlog[n0] !== 6'h25 || xlog[n0+1] !== 6'h05)
      begin bad++; $display("FAIL prio order got %h,%h want 25,05",
        xlog.size() > n0 ? xlog[n0] : 6'h3f, xlog.size() > n0 + 1 ? xlog[n0+1] : 6'h3f); end
    vec++; if (op_rs1_data !== 32'hAB) begin bad++; $display("FAIL prio rs1 got %h want ab", op_rs1_data); end
    vec++; if (op_rs2_data !== 32'h0) begin bad++; $display("FAIL prio rs2 got %h want 0", op_rs2_data); end
    finish_rsp();
  endtask

  task automatic test_skip();
    int cyc, n0 = xlog.size();
    send_op(0, 1, 6, 0);
    wait_rsp(cyc);
    vec++; if (cyc !== 3) begin bad++; $display("FAIL skip latency got %0d want 3", cyc); end
    vec++; if ({op_rs1_data, op_rs2_data} !== 64'h0) begin bad++; $display("FAIL skip data got %h/%h want 0", op_rs1_data, op_rs2_data); end
    vec++; if (xlog.size() !== n0) begin bad++; $display("FAIL skip port xfers got %0d want 0", xlog.size() - n0); end
    finish_rsp();
    wb_rd = 0; wb_data = 32'hFF; wb_valid = 1;
    tick();
    wb_valid = 0;
    vec++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL wb_x0 ready got %b want 1", wb_ready); end
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL wb_x0 busy got %b want 0", busy); end
    tick(); tick(); tick();
    vec++; if (xlog.size() !== n0) begin bad++; $display("FAIL wb_x0 port xfers got %0d want 0", xlog.size() - n0); end
  endtask

  task automatic test_timeout();
    int cyc, r0 = rd_n;
    hang_idx = 3;
    send_op(3, 1, 6, 1);
    wait_rsp(cyc);
    hang_idx = -1;
    vec++; if (cyc !== 9) begin bad++; $display("FAIL tmo latency got %0d want 9", cyc); end
    vec++; if (op_rsp_err !== 1'b1) begin bad++; $display("FAIL tmo err got %b want 1", op_rsp_err); end
    vec++; if (op_rs1_data !== 32'h0) begin bad++; $display("FAIL tmo rs1 got %h want 0", op_rs1_data); end
    vec++; if (op_rs2_data !== 32'h22) begin bad++; $display("FAIL tmo rs2 got %h want 22", op_rs2_data); end
    vec++; if (rd_n - r0 !== 2) begin bad++; $display("FAIL tmo read xfers got %0d want 2", rd_n - r0); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic stable = 1;
    send_op(7, 1, 6, 1);
    wait_rsp(cyc);
    vec++; if (cyc !== 6) begin bad++; $display("FAIL bp latency got %0d want 6", cyc); end
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        vec++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL bp wb_ready got %b want 1", wb_ready); end
        wb_rd = 7; wb_data = 32'h5A; wb_valid = 1;
      end
      tick();
      wb_valid = 0;
      if (!(op_rsp_valid === 1'b1 && op_rs1_data === 32'h77 && op_rs2_data === 32'h22 && op_req_ready === 1'b0))
        stable = 0;
    end
    vec++; if (stable !== 1'b1) begin bad++; $display("FAIL bp response stability got %b want 1", stable); end
    vec++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL bp wb held got ready=%b want 0", wb_ready); end
    finish_rsp();
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL bp idle got busy=%b want 0", busy); end
    tick();
    vec++; if ({rf_idx_valid, rf_idx_op, rf_idx} !== 7'b1_1_00111)
      begin bad++; $display("FAIL bp wb issue got v=%b op=%b idx=%0d want 1 1 7", rf_idx_valid, rf_idx_op, rf_idx); end
    vec++; if (rf_wdata !== 32'h5A) begin bad++; $display("FAIL bp wdata got %h want 5a", rf_wdata); end
    tick(); tick();
    vec++; if (mem[7] !== 32'h5A) begin bad++; $display("FAIL bp written x7 got %h want 5a", mem[7]); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    hang_idx = 3;
    send_op(3, 1, 6, 1);
    tick();
    vec++; if ({rf_rdata_ready, rf_idx_valid} !== 2'b10)
      begin bad++; $display("FAIL rstmid wait got rdy=%b idxv=%b want 1 0", rf_rdata_ready, rf_idx_valid); end
    rst = 1;
    tick();
    vec++; if ({rf_idx_valid, rf_wdata_valid, rf_rdata_ready, op_rsp_valid, busy} !== 5'b0)
      begin bad++; $display("FAIL rstmid flags got %b want 00000",
        {rf_idx_valid, rf_wdata_valid, rf_rdata_ready, op_rsp_valid, busy}); end
    vec++; if ({op_req_ready, wb_ready} !== 2'b11)
      begin bad++; $display("FAIL rstmid ready got %b want 11", {op_req_ready, wb_ready}); end
    rst = 0;
    hang_idx = -1;
    tick();
    send_op(6, 1, 0, 0);
    wait_rsp(cyc);
    vec++; if (op_rs1_data !== 32'h22 || op_rsp_err !== 1'b0)
      begin bad++; $display("FAIL rstmid recovery got rs1=%h err=%b want 22 0", op_rs1_data, op_rsp_err); end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_wb_priority();
    test_skip();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    vec++; if (gap_viol !== 0) begin bad++; $display("FAIL gap violations total got %0d want 0", gap_viol); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/jpc_regfile_sched.md
Name: jpc_regfile_sched

Overview:
- Sequencer and arbiter in front of a single read/write operation port of jpc_regfile.
- Serves two requesters:
  - Decode operand-fetch requester: rs1/rs2. Reads are serialised through the one port and returned together.
  - Writeback requester: rd/data.
- Writeback has priority at operand-fetch start, so fetches observe retired writes. An operand sequence is never preempted.

Parameters:
- DATA_W, 32: register data width; must equal JPC_REGDATA_WIDTH.
- TMO_CYCLES, 255: max cycles waiting for read data before abort; range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- op_req_valid_I  in  1  operand-fetch request valid.
- op_req_ready_O  out  1  operand-fetch request accepted when high with valid.
- op_rs1_I  in  5  rs1 index.
- op_rs1_en_I  in  1  rs1 needed.
- op_rs2_I  in  5  rs2 index.
- op_rs2_en_I  in  1  rs2 needed.
- op_rsp_valid_O  out  1  operand response valid.
- op_rsp_ready_I  in  1  operand response consumed.
- op_rs1_data_O  out  DATA_W  rs1 value.
- op_rs2_data_O  out  DATA_W  rs2 value.
- op_rsp_err_O  out  1  at least one read in this response timed out.
- wb_valid_I  in  1  writeback valid.
- wb_ready_O  out  1  writeback accepted when high with valid.
- wb_rd_I  in  5  destination index.
- wb_data_I  in  DATA_W  writeback data.
- rf_idx_op_O  out  1  0 = read, 1 = write.
- rf_idx_O  out  5  register index.
- rf_idx_valid_O  out  1  index/op valid.
- rf_idx_ready_I  in  1  regfile accepts index.
- rf_rdata_ready_O  out  1  scheduler ready for read data.
- rf_rdata_I  in  DATA_W  read data.
- rf_rdata_valid_I  in  1  read data valid.
- rf_wdata_ready_I  in  1  regfile ready for write data.
- rf_wdata_O  out  DATA_W  write data.
- rf_wdata_valid_O  out  1  write data valid.
- busy_O  out  1  state != IDLE.

Behaviour:
- Reset: synchronous, active-high, on clk.
  - State goes to IDLE; wb_pend and op_pend are cleared.
  - Output values after reset: op_req_ready_O=1, wb_ready_O=1. All rf_* valid/ready outputs, op_rsp_valid_O, op_rsp_err_O and busy_O are 0. All data/index outputs are 0.
  - Asserting rst mid-operation abandons any in-flight access. rf_idx_valid_O drops at the next edge.
- Writeback holding register (one entry):
  - wb_ready_O = !wb_pend.
  - On accept with wb_rd_I != 0: capture rd/data and set wb_pend.
  - On accept with wb_rd_I == 0: the write is dropped, wb_pend stays 0, and no port access occurs.
- Operand request:
  - op_req_ready_O = (state==IDLE) && !op_pend.
  - On accept: capture indices/enables, set op_pend, clear the rs1/rs2 data registers and err.
- IDLE:
  - If wb_pend, go to WB_ISSUE.
  - Else if op_pend, go to RS1_ISSUE.
  - If a writeback and an operand request are both accepted in the same cycle, WB_ISSUE runs first.
- WB_ISSUE:
  - Drives rf_idx_valid_O=1, rf_idx_op_O=1, rf_idx_O=rd, rf_wdata_valid_O=1, rf_wdata_O=data.
  - Completes in the cycle where rf_idx_ready_I && rf_wdata_ready_I. It then clears wb_pend and goes to GAP, returning to IDLE.
- RS1_ISSUE:
  - If !rs1_en or rs1==0: rs1_data=0 and go to RS2_ISSUE next cycle, with no port access.
  - Else: drive a read (op=0, idx=rs1, rf_rdata_ready_O=1). On rf_idx_ready_I, go to RS1_WAIT and clear the timeout counter.
- RS1_WAIT:
  - rf_rdata_ready_O=1 and rf_idx_valid_O=0.
  - On rf_rdata_valid_I: capture rf_rdata_I into rs1_data, then go to GAP, returning to RS2_ISSUE.
  - Else the counter increments. When it reaches TMO_CYCLES: rs1_data=0, err=1, go to GAP.
- RS2_ISSUE / RS2_WAIT: identical to the rs1 states, using the rs2 fields. The exit goes directly to RESP with no GAP.
- GAP: exactly one cycle with all rf_* valid/ready outputs low. It lets the regfile re-arm before the next index.
- RESP:
  - op_rsp_valid_O=1 with data and err held stable.
  - On op_rsp_ready_I: clear op_pend and go to IDLE.
- Writeback arrival during an operand sequence: accepted into the holding register and serviced at the next IDLE. No mid-sequence insertion.
- rf_idx_valid_O is held stable, with index, op and wdata unchanged, until accepted.
- Latency with a zero-wait regfile (idx_ready=1, rdata_valid the cycle after accept):
  - Both operands enabled and nonzero: accept at C0, op_rsp_valid_O high at C6.
  - Both operands skipped: op_rsp_valid_O high at C3.

Test Plan:
- Reset, then op request rs1=5, rs2=6 (en both), regfile x5=0x11, x6=0x22, zero-wait regfile → op_rsp_valid_O at C6 with rs1=0x11, rs2=0x22, err=0. Exactly two read index transfers, each followed by rf_idx_valid_O low for at least 1 cycle.
- Same-cycle wb rd=5, data=0xAB and op request rs1=5 → write transfer precedes the read; response rs1=0xAB.
- op rs1=0, rs2_en=0 → no rf_idx_valid_O assertion; response at C3 with both data=0. wb rd=0 → wb_ready_O stays 1, no port access.
- TMO_CYCLES=4, regfile never asserts rf_rdata_valid_I for rs1=3 → rs1_data=0 and op_rsp_err_O=1. The rs2 read still executes normally.
- Response backpressure: op_rsp_ready_I low for 10 cycles → op_rsp_valid_O and data stable, op_req_ready_O=0. A wb arriving meanwhile is accepted and issued right after the response handshake.
- rst asserted in RS1_WAIT → next cycle rf_* valids are 0, op_rsp_valid_O=0, op_req_ready_O=1, wb_ready_O=1, busy_O=0.
